// File: rtl/systolic_rect.sv
// -----------------------------------------------------------------------------
// systolic_rect
//    Rectangular ROWS x COLS weight-stationary systolic array of signed MAC
//    processing elements.
//
//    Activations enter on the left, one lane per row, and move one PE to the
//    right per cycle. Weights enter on the top, one lane per column, and move
//    down one PE per cycle. Each weight is latched into the shadow bank of the
//    row named by its index. A switch token travels with the activations and
//    copies shadow -> active. Partial sums move down and leave at the bottom,
//    one lane per column.
//
// Ports
//    clk              rising-edge clock
//    rst              asynchronous active-low reset, clears every PE register
//    sys_data_in      ROWS x DATA_WIDTH_IN signed activations, row r -> PE[r][0]
//    sys_valid_in     ROWS activation valid bits
//    sys_switch_in    ROWS switch tokens (shadow -> active weight swap)
//    sys_weight_in    COLS x DATA_WIDTH_IN signed weights, column c -> PE[0][c]
//    sys_index_in     COLS x IDX_W target row of each weight
//    sys_accept_w_in  COLS weight valid bits
//    sys_stall        freezes every register in the array
//    sys_enable_rows  per-row MAC enable
//    sys_enable_cols  per-column MAC enable
//    sys_data_out     COLS x DATA_WIDTH_ACCUM signed partial sums from row ROWS-1
//    sys_valid_out    COLS partial-sum valid bits
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// systolic_rect_pe
//    One MAC cell. All forwarded values are registered, so every hop costs one
//    cycle. ROW_ID selects which weight indices this cell captures.
//
// Ports
//    clk, rst          clock and asynchronous active-low reset
//    stall             hold every register
//    enable            1 = accumulate, 0 = registered psum pass-through
//    data_in .. psum_valid_in   values from the left / upper neighbour
//    data_q  .. psum_valid_q    registered values to the right / lower neighbour
// -----------------------------------------------------------------------------
module systolic_rect_pe #(
   parameter int DATA_WIDTH_IN    = 8,
   parameter int DATA_WIDTH_ACCUM = 32,
   parameter int IDX_W            = 2,
   parameter int ROW_ID           = 0,
   parameter int SATURATE         = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        stall,
   input  logic                        enable,
   input  logic [DATA_WIDTH_IN-1:0]    data_in,
   input  logic                        valid_in,
   input  logic                        switch_in,
   input  logic [DATA_WIDTH_IN-1:0]    weight_in,
   input  logic [IDX_W-1:0]            index_in,
   input  logic                        accept_in,
   input  logic [DATA_WIDTH_ACCUM-1:0] psum_in,
   input  logic                        psum_valid_in,
   output logic [DATA_WIDTH_IN-1:0]    data_q,
   output logic                        valid_q,
   output logic                        switch_q,
   output logic [DATA_WIDTH_IN-1:0]    weight_q,
   output logic [IDX_W-1:0]            index_q,
   output logic                        accept_q,
   output logic [DATA_WIDTH_ACCUM-1:0] psum_q,
   output logic                        psum_valid_q
);

   localparam int DW  = DATA_WIDTH_IN;
   localparam int ACC = DATA_WIDTH_ACCUM;
   localparam logic [IDX_W-1:0] ROW_INDEX = IDX_W'(ROW_ID);

   logic [DW-1:0]         shadow_w;
   logic [DW-1:0]         active_w;
   logic signed [2*DW-1:0] product;
   logic [ACC:0]          addend;
   logic [ACC:0]          product_ext;
   logic [ACC:0]          sum_wide;
   logic [ACC-1:0]        sum_next;

   // Full signed multiply: both operands are sign-extended to the product
   // width first so the low 2*DW bits are the exact signed product.
   assign product = $signed({{DW{data_in[DW-1]}}, data_in}) *
                    $signed({{DW{active_w[DW-1]}}, active_w});

   // The sum is formed one bit wider than the accumulator so that overflow
   // is visible as a disagreement between the top two bits.
   assign product_ext = {{(ACC+1-2*DW){product[2*DW-1]}}, product};
   assign addend      = psum_valid_in ? {psum_in[ACC-1], psum_in} : '0;
   assign sum_wide    = addend + product_ext;

   // Either wrap (drop the extra bit) or clamp to the signed accumulator range
   // when the wide sum does not fit.
   always_comb begin
      sum_next = sum_wide[ACC-1:0];
      if ((SATURATE != 0) && (sum_wide[ACC] != sum_wide[ACC-1])) begin
         if (sum_wide[ACC]) begin
            sum_next = {1'b1, {(ACC-1){1'b0}}};
         end else begin
            sum_next = {1'b0, {(ACC-1){1'b1}}};
         end
      end
   end

   // All cell state. A stall freezes everything including the weight banks.
   // On a simultaneous capture and switch the active bank takes the shadow
   // value from before this edge, because both use the current register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q       <= '0;
         valid_q      <= 1'b0;
         switch_q     <= 1'b0;
         weight_q     <= '0;
         index_q      <= '0;
         accept_q     <= 1'b0;
         shadow_w     <= '0;
         active_w     <= '0;
         psum_q       <= '0;
         psum_valid_q <= 1'b0;
      end else if (!stall) begin
         data_q   <= data_in;
         valid_q  <= valid_in;
         switch_q <= switch_in;
         weight_q <= weight_in;
         index_q  <= index_in;
         accept_q <= accept_in;
         if (accept_in && (index_in == ROW_INDEX)) begin
            shadow_w <= weight_in;
         end
         if (switch_in) begin
            active_w <= shadow_w;
         end
         if (enable) begin
            psum_q       <= sum_next;
            psum_valid_q <= valid_in;
         end else begin
            psum_q       <= psum_in;
            psum_valid_q <= psum_valid_in;
         end
      end
   end

endmodule

module systolic_rect #(
   parameter int ROWS             = 4,
   parameter int COLS             = 4,
   parameter int DATA_WIDTH_IN    = 8,
   parameter int DATA_WIDTH_ACCUM = 32,
   parameter int SATURATE         = 0
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [ROWS*DATA_WIDTH_IN-1:0]         sys_data_in,
   input  logic [ROWS-1:0]                       sys_valid_in,
   input  logic [ROWS-1:0]                       sys_switch_in,
   input  logic [COLS*DATA_WIDTH_IN-1:0]         sys_weight_in,
   input  logic [COLS*((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] sys_index_in,
   input  logic [COLS-1:0]                       sys_accept_w_in,
   input  logic                                  sys_stall,
   input  logic [ROWS-1:0]                       sys_enable_rows,
   input  logic [COLS-1:0]                       sys_enable_cols,
   output logic [COLS*DATA_WIDTH_ACCUM-1:0]      sys_data_out,
   output logic [COLS-1:0]                       sys_valid_out
);

   localparam int DW    = DATA_WIDTH_IN;
   localparam int ACC   = DATA_WIDTH_ACCUM;
   localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   // Registered outputs of every PE, indexed [row][col].
   logic [DW-1:0]    data_q       [ROWS][COLS];
   logic             valid_q      [ROWS][COLS];
   logic             switch_q     [ROWS][COLS];
   logic [DW-1:0]    weight_q     [ROWS][COLS];
   logic [IDX_W-1:0] index_q      [ROWS][COLS];
   logic             accept_q     [ROWS][COLS];
   logic [ACC-1:0]   psum_q       [ROWS][COLS];
   logic             psum_valid_q [ROWS][COLS];

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         logic [DW-1:0]    data_in;
         logic             valid_in;
         logic             switch_in;
         logic [DW-1:0]    weight_in;
         logic [IDX_W-1:0] index_in;
         logic             accept_in;
         logic [ACC-1:0]   psum_in;
         logic             psum_valid_in;

         // Left edge takes the row ports, inner cells take the left neighbour.
         if (c == 0) begin : g_left_port
            assign data_in   = sys_data_in[r*DW +: DW];
            assign valid_in  = sys_valid_in[r];
            assign switch_in = sys_switch_in[r];
         end else begin : g_left_pe
            assign data_in   = data_q[r][c-1];
            assign valid_in  = valid_q[r][c-1];
            assign switch_in = switch_q[r][c-1];
         end

         // Top edge takes the column ports and starts a fresh (invalid) psum.
         if (r == 0) begin : g_top_port
            assign weight_in     = sys_weight_in[c*DW +: DW];
            assign index_in      = sys_index_in[c*IDX_W +: IDX_W];
            assign accept_in     = sys_accept_w_in[c];
            assign psum_in       = '0;
            assign psum_valid_in = 1'b0;
         end else begin : g_top_pe
            assign weight_in     = weight_q[r-1][c];
            assign index_in      = index_q[r-1][c];
            assign accept_in     = accept_q[r-1][c];
            assign psum_in       = psum_q[r-1][c];
            assign psum_valid_in = psum_valid_q[r-1][c];
         end

         systolic_rect_pe #(
            .DATA_WIDTH_IN    (DW),
            .DATA_WIDTH_ACCUM (ACC),
            .IDX_W            (IDX_W),
            .ROW_ID           (r),
            .SATURATE         (SATURATE)
         ) u_pe (
            .clk           (clk),
            .rst           (rst),
            .stall         (sys_stall),
            .enable        (sys_enable_rows[r] & sys_enable_cols[c]),
            .data_in       (data_in),
            .valid_in      (valid_in),
            .switch_in     (switch_in),
            .weight_in     (weight_in),
            .index_in      (index_in),
            .accept_in     (accept_in),
            .psum_in       (psum_in),
            .psum_valid_in (psum_valid_in),
            .data_q        (data_q[r][c]),
            .valid_q       (valid_q[r][c]),
            .switch_q      (switch_q[r][c]),
            .weight_q      (weight_q[r][c]),
            .index_q       (index_q[r][c]),
            .accept_q      (accept_q[r][c]),
            .psum_q        (psum_q[r][c]),
            .psum_valid_q  (psum_valid_q[r][c])
         );
      end
   end

   // Results leave from the bottom row, one lane per column.
   for (genvar c = 0; c < COLS; c++) begin : g_out
      assign sys_data_out[c*ACC +: ACC] = psum_q[ROWS-1][c];
      assign sys_valid_out[c]           = psum_valid_q[ROWS-1][c];
   end

endmodule

// File: tb/tb_systolic_rect.sv
// -----------------------------------------------------------------------------
// tb_systolic_rect
//    Directed bench for a 2x2 systolic_rect (32-bit wrapping accumulator) plus
//    two 16-bit accumulator copies (saturating and wrapping) that share the
//    same stimulus for the overflow cases.
// -----------------------------------------------------------------------------
module tb_systolic_rect;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sys_data_in;
   logic [1:0]  sys_valid_in;
   logic [1:0]  sys_switch_in;
   logic [15:0] sys_weight_in;
   logic [1:0]  sys_index_in;
   logic [1:0]  sys_accept_w_in;
   logic        sys_stall;
   logic [1:0]  sys_enable_rows;
   logic [1:0]  sys_enable_cols;
   logic [63:0] data_out;
   logic [1:0]  valid_out;
   logic [31:0] sat_out;
   logic [1:0]  sat_valid;
   logic [31:0] wrap_out;
   logic [1:0]  wrap_valid;

   int checks   = 0;
   int failures = 0;

   systolic_rect #(
      .ROWS(2), .COLS(2), .DATA_WIDTH_IN(8), .DATA_WIDTH_ACCUM(32), .SATURATE(0)
   ) u_dut (
      .clk(clk), .rst(rst),
      .sys_data_in(sys_data_in), .sys_valid_in(sys_valid_in),
      .sys_switch_in(sys_switch_in), .sys_weight_in(sys_weight_in),
      .sys_index_in(sys_index_in), .sys_accept_w_in(sys_accept_w_in),
      .sys_stall(sys_stall), .sys_enable_rows(sys_enable_rows),
      .sys_enable_cols(sys_enable_cols),
      .sys_data_out(data_out), .sys_valid_out(valid_out)
   );

   systolic_rect #(
      .ROWS(2), .COLS(2), .DATA_WIDTH_IN(8), .DATA_WIDTH_ACCUM(16), .SATURATE(1)
   ) u_dut_sat (
      .clk(clk), .rst(rst),
      .sys_data_in(sys_data_in), .sys_valid_in(sys_valid_in),
      .sys_switch_in(sys_switch_in), .sys_weight_in(sys_weight_in),
      .sys_index_in(sys_index_in), .sys_accept_w_in(sys_accept_w_in),
      .sys_stall(sys_stall), .sys_enable_rows(sys_enable_rows),
      .sys_enable_cols(sys_enable_cols),
      .sys_data_out(sat_out), .sys_valid_out(sat_valid)
   );

   systolic_rect #(
      .ROWS(2), .COLS(2), .DATA_WIDTH_IN(8), .DATA_WIDTH_ACCUM(16), .SATURATE(0)
   ) u_dut_wrap (
      .clk(clk), .rst(rst),
      .sys_data_in(sys_data_in), .sys_valid_in(sys_valid_in),
      .sys_switch_in(sys_switch_in), .sys_weight_in(sys_weight_in),
      .sys_index_in(sys_index_in), .sys_accept_w_in(sys_accept_w_in),
      .sys_stall(sys_stall), .sys_enable_rows(sys_enable_rows),
      .sys_enable_cols(sys_enable_cols),
      .sys_data_out(wrap_out), .sys_valid_out(wrap_valid)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Safety net so the run always ends even if the sequence stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int d0, input int d1,
                                input logic [1:0] v, input logic [1:0] sw);
      sys_data_in   = {d1[7:0], d0[7:0]};
      sys_valid_in  = v;
      sys_switch_in = sw;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("[TB] check %s", tag);
      end
   endtask

   // Weights given as w<row><col>. Row 0 is captured at the top row
   // directly; row 1 is captured one hop later.
   task automatic loadWeights(input int w00, input int w01, input int w10, input int w11);
      sys_weight_in   = {w01[7:0], w00[7:0]};
      sys_index_in    = 2'b00;
      sys_accept_w_in = 2'b11;
      tick();
      sys_weight_in   = {w11[7:0], w10[7:0]};
      sys_index_in    = 2'b11;
      tick();
      sys_weight_in   = '0;
      sys_index_in    = 2'b00;
      sys_accept_w_in = 2'b00;
      tick();
   endtask

   // Switch row 0, then row 1 one cycle later (same skew as the data).
   task automatic switchAll();
      applyStimulus(0, 0, 2'b00, 2'b01);
      tick();
      applyStimulus(0, 0, 2'b00, 2'b10);
      tick();
      applyStimulus(0, 0, 2'b00, 2'b00);
      tick();
   endtask

   // Two skewed vectors a=(x0a,x1a), b=(x0b,x1b). Column 0 results appear two
   // edges after row-0 injection, column 1 one edge later. sw sends a switch
   // token alongside vector a, so a still sees the old active weights.
   task automatic streamTwo(input string tag,
                            input int x0a, input int x1a, input int x0b, input int x1b,
                            input int e0a, input int e0b, input int e1a, input int e1b,
                            input logic c1_on, input logic sw);
      applyStimulus(x0a, 0, 2'b01, {1'b0, sw});
      tick();
      checkOutput({tag, "_v1"}, 32'(valid_out), 32'd0);
      applyStimulus(x0b, x1a, 2'b11, {sw, 1'b0});
      tick();
      checkOutput({tag, "_v2"}, 32'(valid_out), 32'd1);
      checkOutput({tag, "_c0a"}, data_out[31:0], 32'(e0a));
      applyStimulus(0, x1b, 2'b10, 2'b00);
      tick();
      checkOutput({tag, "_v3"}, 32'(valid_out), 32'({c1_on, 1'b1}));
      checkOutput({tag, "_c0b"}, data_out[31:0], 32'(e0b));
      if (c1_on) checkOutput({tag, "_c1a"}, data_out[63:32], 32'(e1a));
      applyStimulus(0, 0, 2'b00, 2'b00);
      tick();
      checkOutput({tag, "_v4"}, 32'(valid_out), 32'({c1_on, 1'b0}));
      if (c1_on) checkOutput({tag, "_c1b"}, data_out[63:32], 32'(e1b));
      tick();
      checkOutput({tag, "_v5"}, 32'(valid_out), 32'd0);
   endtask

   initial begin
      rst             = 1'b0;
      sys_data_in     = '0;
      sys_valid_in    = '0;
      sys_switch_in   = '0;
      sys_weight_in   = '0;
      sys_index_in    = '0;
      sys_accept_w_in = '0;
      sys_stall       = 1'b0;
      sys_enable_rows = 2'b11;
      sys_enable_cols = 2'b11;

      // Reset state, during and after reset
      #12;
      checkOutput("rst_data", data_out[31:0] | data_out[63:32], 32'd0);
      checkOutput("rst_valid", 32'(valid_out), 32'd0);
      rst = 1'b1;
      tick();
      checkOutput("post_rst_valid", 32'(valid_out), 32'd0);

      // Basic 2x2 product with W=[[1,2],[3,4]]
      loadWeights(1, 2, 3, 4);
      switchAll();
      streamTwo("t1", 10, 30, 20, 40, 100, 140, 140, 200, 1'b1, 1'b0);

      // Row 1 disabled: only row-0 products reach the bottom
      sys_enable_rows = 2'b01;
      streamTwo("t2r", 10, 30, 20, 40, 10, 20, 20, 40, 1'b1, 1'b0);
      sys_enable_rows = 2'b11;

      // Column 1 disabled: its valid never rises
      sys_enable_cols = 2'b01;
      streamTwo("t2c", 10, 30, 20, 40, 100, 140, 0, 0, 1'b0, 1'b0);
      sys_enable_cols = 2'b11;

      // Three-cycle stall mid-stream; junk on the ports during the stall
      applyStimulus(10, 0, 2'b01, 2'b00);
      tick();
      checkOutput("st_v0", 32'(valid_out), 32'd0);
      applyStimulus(20, 30, 2'b11, 2'b00);
      tick();
      checkOutput("st_v1", 32'(valid_out), 32'd1);
      checkOutput("st_c0a", data_out[31:0], 32'd100);
      sys_stall = 1'b1;
      applyStimulus(99, 99, 2'b11, 2'b11);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("st_hold_v", 32'(valid_out), 32'd1);
         checkOutput("st_hold_c0", data_out[31:0], 32'd100);
      end
      sys_stall = 1'b0;
      applyStimulus(0, 40, 2'b10, 2'b00);
      tick();
      checkOutput("st_v2", 32'(valid_out), 32'd3);
      checkOutput("st_c0b", data_out[31:0], 32'd140);
      checkOutput("st_c1a", data_out[63:32], 32'd140);
      applyStimulus(0, 0, 2'b00, 2'b00);
      tick();
      checkOutput("st_v3", 32'(valid_out), 32'd2);
      checkOutput("st_c1b", data_out[63:32], 32'd200);
      tick();
      checkOutput("st_v4", 32'(valid_out), 32'd0);

      // Double buffer: load W'=[[5,6],[7,8]] into shadow while W active,
      // switch with vector a (uses W), vector b uses W'
      loadWeights(5, 6, 7, 8);
      streamTwo("t3", 10, 30, 1, 1, 100, 12, 140, 14, 1'b1, 1'b1);

      // Capture and switch on row 0 in the same cycle: active gets old
      // shadow (5) at column 0; column 1 sees the switch a cycle later (9)
      sys_weight_in   = {8'd9, 8'd3};
      sys_index_in    = 2'b00;
      sys_accept_w_in = 2'b11;
      applyStimulus(0, 0, 2'b00, 2'b01);
      tick();
      sys_weight_in   = '0;
      sys_accept_w_in = 2'b00;
      applyStimulus(0, 0, 2'b00, 2'b00);
      tick();
      streamTwo("t3s", 2, 0, 1, 0, 10, 5, 18, 9, 1'b1, 1'b0);
      streamTwo("t3n", 2, 0, 1, 0, 10, 3, 18, 9, 1'b1, 1'b1);

      // Overflow: weights -128 everywhere, data (-128,-128) -> 32768
      loadWeights(-128, -128, -128, -128);
      switchAll();
      applyStimulus(-128, 0, 2'b01, 2'b00);
      tick();
      applyStimulus(0, -128, 2'b10, 2'b00);
      tick();
      checkOutput("sat_v", 32'(sat_valid), 32'd1);
      checkOutput("sat_c0", 32'(sat_out[15:0]), 32'h7FFF);
      checkOutput("wrap_v", 32'(wrap_valid), 32'd1);
      checkOutput("wrap_c0", 32'(wrap_out[15:0]), 32'h8000);
      checkOutput("wide_c0", data_out[31:0], 32'd32768);
      applyStimulus(0, 0, 2'b00, 2'b00);
      tick();
      checkOutput("sat_c1", 32'(sat_out[31:16]), 32'h7FFF);
      checkOutput("wrap_c1", 32'(wrap_out[31:16]), 32'h8000);
      checkOutput("wide_c1", data_out[63:32], 32'd32768);
      tick();

      // Reset in the middle of a stream clears outputs at once and
      // discards both weight banks
      applyStimulus(-128, 0, 2'b01, 2'b00);
      tick();
      applyStimulus(-128, -128, 2'b11, 2'b00);
      tick();
      checkOutput("mr_pre_v", 32'(valid_out), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("mr_c0", data_out[31:0], 32'd0);
      checkOutput("mr_c1", data_out[63:32], 32'd0);
      checkOutput("mr_v", 32'(valid_out), 32'd0);
      applyStimulus(0, 0, 2'b00, 2'b00);
      tick();
      rst = 1'b1;
      applyStimulus(5, 0, 2'b01, 2'b00);
      tick();
      applyStimulus(0, 5, 2'b10, 2'b00);
      tick();
      checkOutput("ar_v0", 32'(valid_out), 32'd1);
      checkOutput("ar_c0", data_out[31:0], 32'd0);
      applyStimulus(0, 0, 2'b00, 2'b00);
      tick();
      checkOutput("ar_v1", 32'(valid_out), 32'd2);
      checkOutput("ar_c1", data_out[63:32], 32'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/systolic_rect.md
Name: systolic_rect

Overview:
- Parametrised successor to the square weight-stationary array: a rectangular ROWS x COLS grid of MAC PEs.
- Activations enter from the left, one row per lane, and flow right. Weights enter from the top and flow down; each weight is captured by the row selected by its index. Partial sums flow down and exit at the bottom, one lane per column.
- New over the square array:
  - independent ROWS/COLS;
  - double-buffered weights with an explicit switch;
  - a global stall;
  - optional saturating accumulation.

Parameters:
ROWS, 4, PE rows (activation lanes); >=1
COLS, 4, PE columns (weight/output lanes); >=1
DATA_WIDTH_IN, 8, signed activation/weight width
DATA_WIDTH_ACCUM, 32, signed partial-sum width; >= 2*DATA_WIDTH_IN
SATURATE, 0, 1 = clamp accumulation to signed ACCUM range; 0 = two's-complement wrap

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
sys_data_in  in  ROWS x DATA_WIDTH_IN  signed activation, row r enters PE[r][0]
sys_valid_in  in  ROWS x 1  activation valid per row
sys_switch_in  in  ROWS x 1  swap shadow->active weight, propagates right along the row
sys_weight_in  in  COLS x DATA_WIDTH_IN  signed weight, column c enters PE[0][c]
sys_index_in  in  COLS x max(1,$clog2(ROWS))  target row for the weight
sys_accept_w_in  in  COLS x 1  weight valid, propagates down the column
sys_stall  in  1  freeze entire array
sys_enable_rows  in  ROWS  per-row MAC enable
sys_enable_cols  in  COLS  per-column MAC enable
sys_data_out  out  COLS x DATA_WIDTH_ACCUM  signed psum from PE[ROWS-1][c]
sys_valid_out  out  COLS x 1  psum valid

Behaviour:
- Reset: every PE register (data, valid, switch, weight, index, accept, shadow_w, active_w, psum, psum_valid) is cleared to 0 asynchronously. Hence sys_data_out = 0 and sys_valid_out = 0 during and after reset until new data arrives.
- Hop timing: each PE registers everything it forwards; one cycle per hop.
  - Right: data, valid, switch.
  - Down: weight, index, accept, psum, psum_valid.
- PE[r][c] inputs: left-side inputs come from PE[r][c-1] (ports for c=0); top-side inputs come from PE[r-1][c] (ports for r=0). Row 0 psum_in = 0 and psum_valid_in = 0.
- Weight capture: accept_in && index_in == r -> shadow_w <= weight_in. Weight/index/accept are forwarded down regardless of capture.
- Switch: switch_in -> active_w <= shadow_w.
  - Capture and switch in the same cycle: active_w takes the OLD shadow_w; shadow_w takes the new weight.
- Enabled PE (sys_enable_rows[r] && sys_enable_cols[c]):
  - psum_q <= (psum_valid_in ? psum_in : 0) + sext(data_in * active_w);
  - psum_valid_q <= valid_in.
  - The product is a full signed 2*DATA_WIDTH_IN multiply, sign-extended to ACCUM width.
- Disabled PE: psum_q <= psum_in; psum_valid_q <= psum_valid_in (registered pass-through). Data and weight forwarding are unaffected.
- SATURATE=1: the sum is computed one bit wider, then clamped to [-2^(ACCUM-1), 2^(ACCUM-1)-1]. SATURATE=0: the sum is truncated (wraps).
- Skew: the caller presents row r data r cycles after row 0 of the same vector. The psum from PE[r-1][c] then meets row-r data at PE[r][c].
- Latency: vector injected at row 0 in cycle t -> sys_valid_out[c] high in cycle t+c+ROWS, plus any stall cycles.
- Stall: sys_stall=1 -> no register in the array updates; all port inputs that cycle are ignored and outputs hold. Deassertion resumes exactly where it left off with no lost or duplicated data.
- Enables are sampled each cycle (not latched). Changing them mid-stream affects only the PEs computing in that cycle.
- Reset mid-operation: all in-flight data, psums and both weight banks are discarded. The first valid output after release requires fresh weights and a fresh switch.
- Weights with index >= ROWS are never captured by any PE.

Test Plan:
1. ROWS=2, COLS=2: load W=[[1,2],[3,4]] (col0 idx0=1, idx1=3; col1 idx0=2, idx1=4), then switch rows 0,1 with row skew; inject vectors (10,30) and (20,40) skewed -> col0 outputs 100 then 140 at cycle t+2; col1 outputs 140 then 200 at t+3; valid exactly 2 cycles per column.
2. Same setup with sys_enable_rows=2'b01 -> col0 outputs 10, 20; col1 outputs 20, 40. With sys_enable_cols=2'b01, col1 sys_valid_out never asserts.
3. Double buffer: while vectors stream with W active, load W'=[[5,6],[7,8]] into shadow, then switch; vectors after the switch use W' (x=(1,1) -> 12, 14) and earlier vectors still use W. Also, capture and switch in the same cycle -> active gets the old shadow.
4. Stall: assert sys_stall for 3 cycles mid-stream in test 1 -> identical output values, each delayed by exactly 3 cycles, outputs held constant during the stall.
5. DATA_WIDTH_IN=8, ACCUM=16, ROWS=2: weights -128 in both rows, data (-128,-128) -> SATURATE=1 gives 32767; SATURATE=0 gives -32768.
6. Assert reset (low) mid-stream -> outputs 0 immediately (asynchronous); after release, a vector without reloaded weights yields 0, not stale sums.
